// File: rtl/id_stage_pipe.sv
// Decode-to-execute stage: DEPTH-entry FIFO of decoded instructions with
// head-load memory request issue and load-use hazard holding at the input.
module id_stage_pipe #(
  parameter int XLEN     = 32,
  parameter int AW       = 32,
  parameter int RAW      = 5,
  parameter int DEPTH    = 2,
  parameter int LU_STALL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_ins_i,
  input  logic [AW-1:0]   in_addr_i,
  input  logic [XLEN-1:0] in_rs1_data_i,
  input  logic [XLEN-1:0] in_rs2_data_i,
  input  logic [XLEN-1:0] in_imm_i,
  input  logic [RAW-1:0]  in_rd_i,
  input  logic            in_is_load_i,
  input  logic [AW-1:0]   in_mem_addr_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [31:0]     out_ins_o,
  output logic [AW-1:0]   out_addr_o,
  output logic [XLEN-1:0] out_rs1_data_o,
  output logic [XLEN-1:0] out_rs2_data_o,
  output logic [XLEN-1:0] out_imm_o,
  output logic [RAW-1:0]  out_rd_o,
  output logic            out_is_load_o,
  output logic            mem_req_o,
  output logic [AW-1:0]   mem_addr_o,
  input  logic            mem_gnt_i
);

  localparam int          PW         = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT   = (PW+1)'(DEPTH);
  localparam logic [2:0]  STALL_INIT = 3'(LU_STALL);

  logic [31:0]     r_insMem     [DEPTH];
  logic [AW-1:0]   r_addrMem    [DEPTH];
  logic [XLEN-1:0] r_rs1Mem     [DEPTH];
  logic [XLEN-1:0] r_rs2Mem     [DEPTH];
  logic [XLEN-1:0] r_immMem     [DEPTH];
  logic [RAW-1:0]  r_rdMem      [DEPTH];
  logic            r_isLoadMem  [DEPTH];
  logic [AW-1:0]   r_memAddrMem [DEPTH];

  logic [PW:0]     r_count;
  logic [PW-1:0]   r_wrPtr;
  logic [PW-1:0]   r_rdPtr;
  logic            r_granted;
  logic [2:0]      r_cdCnt;
  logic [RAW-1:0]  r_cdRd;

  logic [PW-1:0]   w_entryOff   [DEPTH];
  logic [DEPTH-1:0] w_entryValid;
  logic [RAW-1:0]  w_rs1;
  logic [RAW-1:0]  w_rs2;
  logic            w_hazard;
  logic            w_headValid;
  logic            w_headIsLoad;
  logic            w_push;
  logic            w_pop;

  assign w_rs1 = RAW'(in_ins_i[19:15]);
  assign w_rs2 = RAW'(in_ins_i[24:20]);

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_entryOff[i]   = PW'(i) - r_rdPtr;
      w_entryValid[i] = ({1'b0, w_entryOff[i]} < r_count);
    end
  end

  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_entryValid[i] && r_isLoadMem[i] &&
          (((w_rs1 != '0) && (w_rs1 == r_rdMem[i])) ||
           ((w_rs2 != '0) && (w_rs2 == r_rdMem[i]))))
        w_hazard = 1'b1;
    end
    if ((r_cdCnt != 3'd0) &&
        (((w_rs1 != '0) && (w_rs1 == r_cdRd)) ||
         ((w_rs2 != '0) && (w_rs2 == r_cdRd))))
      w_hazard = 1'b1;
  end

  assign w_headValid  = (r_count != '0);
  assign w_headIsLoad = w_headValid && r_isLoadMem[r_rdPtr];

  assign in_ready_o  = (r_count < FULL_CNT) && !w_hazard && !flush_i;
  assign mem_req_o   = w_headIsLoad && !r_granted;
  assign out_valid_o = w_headValid && (!w_headIsLoad || r_granted);
  assign w_push      = in_valid_i && in_ready_o;
  assign w_pop       = out_valid_o && out_ready_i;

  // Head fields are forced to zero when empty so reset shows clean outputs.
  assign out_ins_o      = w_headValid ? r_insMem[r_rdPtr]     : '0;
  assign out_addr_o     = w_headValid ? r_addrMem[r_rdPtr]    : '0;
  assign out_rs1_data_o = w_headValid ? r_rs1Mem[r_rdPtr]     : '0;
  assign out_rs2_data_o = w_headValid ? r_rs2Mem[r_rdPtr]     : '0;
  assign out_imm_o      = w_headValid ? r_immMem[r_rdPtr]     : '0;
  assign out_rd_o       = w_headValid ? r_rdMem[r_rdPtr]      : '0;
  assign out_is_load_o  = w_headIsLoad;
  assign mem_addr_o     = w_headValid ? r_memAddrMem[r_rdPtr] : '0;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_insMem[r_wrPtr]     <= in_ins_i;
      r_addrMem[r_wrPtr]    <= in_addr_i;
      r_rs1Mem[r_wrPtr]     <= in_rs1_data_i;
      r_rs2Mem[r_wrPtr]     <= in_rs2_data_i;
      r_immMem[r_wrPtr]     <= in_imm_i;
      r_rdMem[r_wrPtr]      <= in_rd_i;
      r_isLoadMem[r_wrPtr]  <= in_is_load_i;
      r_memAddrMem[r_wrPtr] <= in_mem_addr_i;
    end
  end

  // Flush wins over push, pop and grant arriving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= '0;
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_granted <= 1'b0;
      r_cdCnt   <= 3'd0;
      r_cdRd    <= '0;
    end else if (flush_i) begin
      r_count   <= '0;
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_granted <= 1'b0;
      r_cdCnt   <= 3'd0;
    end else begin
      if (w_push)
        r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)
        r_rdPtr <= r_rdPtr + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (!w_push && w_pop)
        r_count <= r_count - 1'b1;

      if (w_pop)
        r_granted <= 1'b0;
      else if (mem_req_o && mem_gnt_i)
        r_granted <= 1'b1;

      // A departing load keeps its rd blocked for LU_STALL more cycles.
      if (w_pop && w_headIsLoad && (r_rdMem[r_rdPtr] != '0)) begin
        r_cdRd  <= r_rdMem[r_rdPtr];
        r_cdCnt <= STALL_INIT;
      end else if (r_cdCnt != 3'd0) begin
        r_cdCnt <= r_cdCnt - 3'd1;
      end
    end
  end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised decode-to-execute pipeline stage, the successor to the fixed single-register ID/EX latch. It sits between instruction decode and EX, buffering decoded instructions in a DEPTH-entry FIFO with valid/ready handshakes on both sides. It issues the early memory read request for a load at the FIFO head, and detects load-use hazards so dependent instructions are held at its input. Flush empties the stage in one cycle.

## Interface
- XLEN, 32, register/immediate data width
- AW, 32, instruction address width
- RAW, 5, register address width
- DEPTH, 2, FIFO entries (power of 2, ≥2)
- LU_STALL, 1, cycles a dependent instruction is held after its producing load leaves the stage (0..7)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush_i  in  1  discard all stage contents
- in_valid_i  in  1  decoded instruction offered
- in_ready_o  out  1  stage accepts this cycle
- in_ins_i  in  32  raw instruction (rs1=[19:15], rs2=[24:20])
- in_addr_i  in  AW  instruction address
- in_rs1_data_i, in_rs2_data_i  in  XLEN  operand values
- in_imm_i  in  XLEN  decoded immediate
- in_rd_i  in  RAW  destination register
- in_is_load_i  in  1  instruction is a load
- in_mem_addr_i  in  AW  load address (valid when in_is_load_i)
- out_valid_o  out  1  head entry presented to EX
- out_ready_i  in  1  EX accepts head
- out_ins_o, out_addr_o, out_rs1_data_o, out_rs2_data_o, out_imm_o, out_rd_o, out_is_load_o  out  as inputs  head entry fields
- mem_req_o  out  1  read request for head load
- mem_addr_o  out  AW  head load address
- mem_gnt_i  in  1  bus grant for mem_req_o

## Operation
- Push: in_valid_i && in_ready_o. Pop: out_valid_o && out_ready_i.
- in_ready_o = (count < DEPTH) && !hazard && !flush_i. Push while full is never accepted, even with a simultaneous pop.
- hazard: the in_ins_i rs1 or rs2 field is nonzero and equals the rd of either (a) any valid FIFO entry with is_load = 1, or (b) cd_rd while cd_cnt ≠ 0.
- On popping a load with rd ≠ 0: cd_rd ← rd and cd_cnt ← LU_STALL. Otherwise a nonzero cd_cnt decrements by 1 per cycle.
- Head request state (granted flag, single register):
  - mem_req_o = head valid && head is_load && !granted.
  - mem_addr_o = head mem_addr.
  - mem_gnt_i while mem_req_o is high sets granted. Pop clears it.
- out_valid_o = head valid && (!head is_load || granted). Non-loads pass with no memory traffic.
- When the stage is empty, out_* data fields are don't-care and out_is_load_o is 0.
- Pointers wrap modulo DEPTH. count has log2(DEPTH)+1 bits.
- flush_i: at the next edge, count, pointers, granted and cd_cnt all become 0. Flush overrides any push, pop or grant in the same cycle.

## Timing
- Reset values: count 0, pointers 0, granted 0, cd_cnt 0.
- Outputs during reset: in_ready_o 1, out_valid_o 0, mem_req_o 0, all out_* data 0.
- An asserted rst clears the stage mid-operation. A pending mem_req_o drops at once (asynchronous). An outstanding grant is forgotten.
- Latency, non-load: pushed at edge N, out_valid_o high in cycle N+1.
- Latency, load: mem_req_o high in cycle N+1. If mem_gnt_i arrives in cycle N+1, out_valid_o goes high in N+2.
- Throughput: 1 instruction/cycle with out_ready_i held high and no loads. A load costs at least 1 extra cycle.
- in_ready_o, out_valid_o and mem_req_o are combinational from registered state plus in_ins_i and flush_i. No path exists from out_ready_i to in_ready_o.
- A load rd = x0 never creates a hazard.

## Test plan
- Reset, then 4 back-to-back ADDs, out_ready_i=1 → each appears on out_* 1 cycle after push, in_ready_o stays 1, mem_req_o stays 0.
- LW x5 at mem_addr 0x100, grant withheld 3 cycles → mem_req_o=1 with mem_addr_o=0x100 for 3 cycles, out_valid_o=0. Grant in cycle 4 → out_valid_o=1 in cycle 5.
- LW x5 then ADD x6,x5,x1, LU_STALL=1 → in_ready_o=0 while the load is in the FIFO and for 1 cycle after its pop, then the ADD is accepted. Same sequence with LW x0 → no stall.
- DEPTH=2, out_ready_i=0, 3 pushes offered → 2 accepted, in_ready_o=0 on the third. One pop → third accepted the following cycle.
- Flush asserted with 2 entries, one an ungranted load, and mem_gnt_i=1 the same cycle → next cycle count=0, mem_req_o=0, out_valid_o=0, cd_cnt=0.
- rst asserted mid-transfer with out_valid_o=1 → out_valid_o, mem_req_o and all out_* data 0 immediately. After release, the first push behaves as in scenario 1.
